logic_gate_unit: RTL and testbench
==================================

// Module: logic_gate_unit
// PURPOSE
//   Parametrised, registered multi-operand bitwise gate with a run-time selected function.
//   Successor to the lab's single-function 2-input combinational gates.
//   Adds valid/ready streaming and a built-in exhaustive truth-table sweep engine.
//   The sweep lets a bench or top level print a full truth table without external stimulus.
// PARAMETERS
//   WIDTH  4  bits per operand; the gate is applied bitwise across the operand vectors
//   NIN    2  number of operands, legal range 2..4
// PORTS
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   op           in   3           function: 0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 NOT op0,7 BUF op0
//   in_valid     in   1           in_data/op valid
//   in_ready     out  1           unit accepts in_data this cycle
//   in_data      in   NIN*WIDTH   operand k = in_data[k*WIDTH +: WIDTH]
//   out_valid    out  1           out_data valid
//   out_ready    in   1           consumer accepts out_data
//   out_data     out  WIDTH       registered result
//   out_vec      out  NIN         sweep combination that produced out_data (0 for normal transfers)
//   sweep_start  in   1           1-cycle pulse: begin exhaustive sweep with current op
//   sweep_busy   out  1           sweep in progress
//   sweep_done   out  1           1-cycle pulse after last sweep result is accepted
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, out_data=0, out_vec=0, sweep_busy=0, sweep_done=0, FSM=IDLE.
//   Reset mid-sweep or mid-transfer aborts it. No sweep_done is issued and pending output is dropped.
// - Datapath:
//   - One output register stage. Transfer on in_valid&&in_ready; result appears next cycle (latency 1).
//   - in_ready = !out_valid || out_ready in IDLE.
//   - in_ready = 0 while sweep_busy.
//   - Reductions (AND/OR/XOR family) span all NIN operands, bit by bit. NOT/BUF use operand 0 only.
//   - op is sampled with each transfer. A later change of op does not alter a held result.
//   - out_data/out_vec hold stable while out_valid && !out_ready. No result is lost or duplicated.
// - FSM states:
//   - IDLE:
//     - sweep_start=1 -> latch op, cnt=0, go to SWEEP.
//     - sweep_start is honoured even if an in_valid transfer occurs the same cycle. That transfer
//       completes normally and its result is emitted before the first sweep result.
//   - SWEEP:
//     - Whenever the output register is free or being drained, internally issue combination cnt:
//       operand k = {WIDTH{cnt[k]}}, out_vec=cnt. Then cnt++.
//     - After issuing cnt = 2^NIN-1, go to DRAIN.
//     - sweep_start ignored.
//   - DRAIN: when the last sweep result is accepted (out_valid&&out_ready), pulse sweep_done for
//     1 cycle and go to IDLE.
//   - sweep_busy=1 in SWEEP and DRAIN.
// - Counter: NIN-bit cnt plus terminal detect. No wrap past 2^NIN-1; exactly 2^NIN results per sweep.
// - Full throughput: with out_ready held 1, one result per cycle. A sweep of 2^NIN results takes
//   2^NIN+1 cycles from sweep_start to sweep_done.
// - op >= 6 with NIN operands: operands 1..NIN-1 are ignored (sweep still runs 2^NIN entries).
// TESTING
// 1. WIDTH=4,NIN=2,op=3:
//    stimulus: in_data={4'h0,4'h0}, then {4'h5,4'hA}, out_ready=1
//    required: out_data 4'hF then 4'h0, each 1 cycle after transfer.
// 2. Backpressure:
//    stimulus: out_ready=0 for 3 cycles after a NAND transfer {4'hC,4'hA}
//    required: out_data=4'h7 held stable, in_ready=0 until out_ready=1, no duplicate result.
// 3. NOR sweep, NIN=2, out_ready=1:
//    required: out_vec 0,1,2,3 with out_data F,0,0,0; sweep_done 5 cycles after sweep_start.
// 4. XOR sweep, NIN=3, out_ready toggling 1/0:
//    required: 8 results out_data 0,F,F,0,F,0,0,F in order; sweep_done exactly once; in_ready=0 throughout.
// 5. Reset at 2nd sweep result:
//    stimulus: assert rst_n=0
//    required: all outputs 0 immediately (async); no sweep_done; next sweep_start restarts at out_vec=0.
// 6. Simultaneous in_valid transfer and sweep_start in IDLE:
//    required: external result emitted first with out_vec=0, then the full sweep.

Source files
------------

// File: rtl/logic_gate_unit_if.sv
// logic_gate_unit_if: streaming operand/result bus plus sweep control for logic_gate_unit
interface logic_gate_unit_if #(
    parameter int WIDTH = 4,
    parameter int NIN   = 2
);
    logic [2:0]           op;
    logic                 in_valid;
    logic                 in_ready;
    logic [NIN*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [NIN-1:0]       out_vec;
    logic                 sweep_start;
    logic                 sweep_busy;
    logic                 sweep_done;

    modport master (
        output op, in_valid, in_data, out_ready, sweep_start,
        input  in_ready, out_valid, out_data, out_vec, sweep_busy, sweep_done
    );
    modport slave (
        input  op, in_valid, in_data, out_ready, sweep_start,
        output in_ready, out_valid, out_data, out_vec, sweep_busy, sweep_done
    );
endinterface

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered NIN-operand bitwise gate with run-time op and truth-table sweep engine
module logic_gate_unit #(
    parameter int WIDTH = 4,
    parameter int NIN   = 2
) (
    input logic clk,
    input logic rst_n,
    logic_gate_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t               state_q;
    logic [2:0]           sweep_op_q;
    logic [NIN-1:0]       cnt_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [NIN-1:0]       out_vec_q;
    logic                 out_valid_q;
    logic                 sweep_done_q;
    logic                 free;
    logic                 take;
    logic                 issue;
    logic [NIN*WIDTH-1:0] sweep_data;

    function automatic logic [WIDTH-1:0] gate(input logic [2:0] f, input logic [NIN*WIDTH-1:0] d);
        logic [WIDTH-1:0] a, o, x, b;
        b = d[WIDTH-1:0];
        a = b;
        o = b;
        x = b;
        for (int k = 1; k < NIN; k++) begin
            a = a & d[k*WIDTH +: WIDTH];
            o = o | d[k*WIDTH +: WIDTH];
            x = x ^ d[k*WIDTH +: WIDTH];
        end
        return f == 3'd0 ? a : f == 3'd1 ? o : f == 3'd2 ? ~a : f == 3'd3 ? ~o :
               f == 3'd4 ? x : f == 3'd5 ? ~x : f == 3'd6 ? ~b : b;
    endfunction

    // Sweep operand k is all-ones or all-zeros according to bit k of the combination
    always_comb begin
        sweep_data = '0;
        for (int k = 0; k < NIN; k++) sweep_data[k*WIDTH +: WIDTH] = {WIDTH{cnt_q[k]}};
    end

    assign free  = !out_valid_q || bus.out_ready;
    assign take  = bus.in_valid && bus.in_ready;
    assign issue = (state_q == SWEEP) && free;

    assign bus.in_ready   = (state_q == IDLE) && free;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.sweep_busy = state_q != IDLE;
    assign bus.sweep_done = sweep_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sweep_op_q   <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_vec_q    <= '0;
            out_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            if (take) begin
                out_data_q  <= gate(bus.op, bus.in_data);
                out_vec_q   <= '0;
                out_valid_q <= 1'b1;
            end else if (issue) begin
                out_data_q  <= gate(sweep_op_q, sweep_data);
                out_vec_q   <= cnt_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (bus.sweep_start) begin
                    sweep_op_q <= bus.op;
                    cnt_q      <= '0;
                    state_q    <= SWEEP;
                end
                SWEEP: if (issue) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {NIN{1'b1}}) state_q <= DRAIN;
                end
                DRAIN: if (out_valid_q && bus.out_ready) begin
                    sweep_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit: scoreboard bench for logic_gate_unit with NIN=2 and NIN=3 instances
module tb_logic_gate_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(4), .NIN(2)) b2();
    logic_gate_unit_if #(.WIDTH(4), .NIN(3)) b3();
    logic_gate_unit #(.WIDTH(4), .NIN(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    logic_gate_unit #(.WIDTH(4), .NIN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    typedef struct packed {logic [3:0] d; logic [3:0] v;} exp_t;
    exp_t q2[$];
    exp_t q3[$];
    int vectors = 0;
    int miscompares = 0;
    int acc2 = 0;
    int done2 = 0;
    int done3 = 0;
    logic rnd_ready = 1'b0;

    // Per-bit reference: count ones across the operands, then classify
    function automatic logic [3:0] model(input logic [2:0] op, input int n, input logic [11:0] d);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(d[k*4+b]);
            case (op)
                3'd0: r[b] = ones == n;
                3'd1: r[b] = ones != 0;
                3'd2: r[b] = ones != n;
                3'd3: r[b] = ones == 0;
                3'd4: r[b] = ones % 2 == 1;
                3'd5: r[b] = ones % 2 == 0;
                3'd6: r[b] = !d[b];
                default: r[b] = d[b];
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        if (b2.out_valid && b2.out_ready) begin
            vectors++;
            acc2++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL out2_unexpected got data=%h vec=%0d expected nothing", b2.out_data, b2.out_vec);
            end else begin
                e = q2.pop_front();
                if ({b2.out_data, 2'b00, b2.out_vec} !== e) begin
                    miscompares++;
                    $display("FAIL out2 got data=%h vec=%0d expected data=%h vec=%0d", b2.out_data, b2.out_vec, e.d, e.v);
                end
            end
        end
        if (b3.out_valid && b3.out_ready) begin
            vectors++;
            if (q3.size() == 0) begin
                miscompares++;
                $display("FAIL out3_unexpected got data=%h vec=%0d expected nothing", b3.out_data, b3.out_vec);
            end else begin
                e = q3.pop_front();
                if ({b3.out_data, 1'b0, b3.out_vec} !== e) begin
                    miscompares++;
                    $display("FAIL out3 got data=%h vec=%0d expected data=%h vec=%0d", b3.out_data, b3.out_vec, e.d, e.v);
                end
            end
        end
        if (b2.sweep_done) done2++;
        if (b3.sweep_done) done3++;
    end

    always @(posedge clk) if (rnd_ready) #1 b2.out_ready = 1'($urandom_range(0, 1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [2:0] op, input logic [7:0] d, input logic [3:0] e);
        logic ok;
        ok = 1'b0;
        b2.op = op;
        b2.in_data = d;
        b2.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b2.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send2_timeout got in_ready=0 expected 1");
        end else q2.push_back({e, 4'd0});
        step();
        b2.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({b2.out_valid, b2.out_data, b2.out_vec, b2.sweep_busy, b2.sweep_done, b2.in_ready} !== 10'b0_0000_00_0_0_1) begin
            miscompares++;
            $display("FAIL reset_state got v=%b d=%h vec=%0d busy=%b done=%b rdy=%b expected 0,0,0,0,0,1",
                     b2.out_valid, b2.out_data, b2.out_vec, b2.sweep_busy, b2.sweep_done, b2.in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nor_basic();
        b2.out_ready = 1'b1;
        send2(3'd3, 8'h00, 4'hF);
        vectors++;
        if ({b2.out_valid, b2.out_data} !== 5'h1F) begin
            miscompares++;
            $display("FAIL nor_latency got v=%b d=%h expected v=1 d=f", b2.out_valid, b2.out_data);
        end
        send2(3'd3, 8'h5A, 4'h0);
        vectors++;
        if ({b2.out_valid, b2.out_data} !== 5'h10) begin
            miscompares++;
            $display("FAIL nor_latency2 got v=%b d=%h expected v=1 d=0", b2.out_valid, b2.out_data);
        end
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        int base;
        int bad;
        bad = 0;
        b2.out_ready = 1'b0;
        send2(3'd2, 8'hCA, 4'h7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!(b2.out_valid === 1'b1 && b2.out_data === 4'h7 && b2.in_ready === 1'b0)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold got %0d bad cycles (d=%h rdy=%b) expected 0", bad, b2.out_data, b2.in_ready);
        end
        base = acc2;
        step();
        b2.out_ready = 1'b1;
        repeat (3) step();
        vectors++;
        if (acc2 != base + 1) begin
            miscompares++;
            $display("FAIL backpressure_count got %0d accepts expected 1", acc2 - base);
        end
    endtask

    task automatic test_nor_sweep();
        int got;
        got = -1;
        b2.op = 3'd3;
        b2.sweep_start = 1'b1;
        q2.push_back({4'hF, 4'd0});
        q2.push_back({4'h0, 4'd1});
        q2.push_back({4'h0, 4'd2});
        q2.push_back({4'h0, 4'd3});
        step();
        b2.sweep_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 2) begin
                vectors++;
                if ({b2.sweep_busy, b2.in_ready} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL nor_sweep_busy got busy=%b rdy=%b expected 1,0", b2.sweep_busy, b2.in_ready);
                end
            end
            if (b2.sweep_done) begin
                got = c;
                break;
            end
        end
        vectors++;
        if (got != 5) begin
            miscompares++;
            $display("FAIL nor_sweep_done_cycles got %0d expected 5", got);
        end
        repeat (2) step();
    endtask

    task automatic test_xor_sweep3();
        logic [7:0] pat;
        int bad;
        bad = 0;
        pat = 8'b1001_0110;
        for (int i = 0; i < 8; i++) q3.push_back({{4{pat[i]}}, 4'(i)});
        b3.op = 3'd4;
        b3.out_ready = 1'b1;
        b3.sweep_start = 1'b1;
        step();
        b3.sweep_start = 1'b0;
        for (int c = 0; c < 60 && done3 == 0; c++) begin
            b3.out_ready = ~b3.out_ready;
            step();
            if (b3.sweep_busy && b3.in_ready) bad++;
        end
        b3.out_ready = 1'b1;
        repeat (4) step();
        vectors++;
        if (done3 != 1 || q3.size() != 0) begin
            miscompares++;
            $display("FAIL xor_sweep3 got done=%0d left=%0d expected done=1 left=0", done3, q3.size());
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL xor_sweep3_ready got %0d busy cycles with in_ready=1 expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int base;
        base = done2;
        b2.op = 3'd0;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) q2.push_back({(i == 3) ? 4'hF : 4'h0, 4'(i)});
        b2.sweep_start = 1'b1;
        step();
        b2.sweep_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.out_valid && b2.out_vec == 2'd1) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        q2.delete();
        vectors++;
        if ({b2.out_valid, b2.out_data, b2.out_vec, b2.sweep_busy, b2.sweep_done} !== 9'b0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b d=%h vec=%0d busy=%b done=%b expected all 0",
                     b2.out_valid, b2.out_data, b2.out_vec, b2.sweep_busy, b2.sweep_done);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        vectors++;
        if (done2 != base) begin
            miscompares++;
            $display("FAIL reset_no_done got %0d sweep_done pulses expected 0", done2 - base);
        end
        for (int i = 0; i < 4; i++) q2.push_back({(i == 3) ? 4'hF : 4'h0, 4'(i)});
        b2.sweep_start = 1'b1;
        step();
        b2.sweep_start = 1'b0;
        for (int i = 0; i < 30 && done2 == base; i++) step();
        vectors++;
        if (done2 != base + 1 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL restart_sweep got done=%0d left=%0d expected done=1 left=0", done2 - base, q2.size());
        end
        step();
    endtask

    task automatic test_simultaneous();
        int base;
        base = done2;
        b2.out_ready = 1'b1;
        b2.op = 3'd1;
        b2.in_data = 8'h12;
        b2.in_valid = 1'b1;
        b2.sweep_start = 1'b1;
        q2.push_back({4'h3, 4'd0});
        for (int i = 0; i < 4; i++) q2.push_back({(i == 0) ? 4'h0 : 4'hF, 4'(i)});
        @(negedge clk);
        vectors++;
        if (b2.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_ready got %b expected 1", b2.in_ready);
        end
        step();
        b2.in_valid = 1'b0;
        b2.sweep_start = 1'b0;
        for (int i = 0; i < 30 && done2 == base; i++) step();
        vectors++;
        if (done2 != base + 1 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL simul_sweep got done=%0d left=%0d expected done=1 left=0", done2 - base, q2.size());
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [7:0] d;
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            send2(op, d, model(op, 2, {4'h0, d}));
        end
        rnd_ready = 1'b0;
        step();
        b2.out_ready = 1'b1;
        repeat (3) step();
        vectors++;
        if (q2.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_back_drain got %0d pending expected 0", q2.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        {b2.op, b2.in_valid, b2.in_data, b2.out_ready, b2.sweep_start} = '0;
        {b3.op, b3.in_valid, b3.in_data, b3.out_ready, b3.sweep_start} = '0;
        test_reset();
        test_nor_basic();
        test_backpressure();
        test_nor_sweep();
        test_xor_sweep3();
        test_reset_mid_sweep();
        test_simultaneous();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
